// File: rtl/ps2_key_pkg.sv
// Shared constants, state encoding and step result type for the PS/2 set-2
// key-event encoder.
package ps2_key_pkg;

    localparam int KEY_W = 65;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_E1 = 8'hE1;
    localparam logic [7:0] BRK_F0 = 8'hF0;

    // Keyboard response / status bytes, never part of a key event
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
    localparam logic [7:0] RSP_ECHO    = 8'hEE;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;
    localparam logic [7:0] RSP_BAT_ERR = 8'hFC;
    localparam logic [7:0] RSP_OVR0    = 8'h00;
    localparam logic [7:0] RSP_OVR1    = 8'hFF;

    localparam logic [7:0] KEY_LSHIFT = 8'h12;
    localparam logic [7:0] KEY_PRTSC  = 8'h7C;

    typedef enum logic [2:0] {
        IDLE,
        PREFIX,
        PAUSE,
        HOLD_MAKE,
        HOLD_BRK
    } ps2_state_e;

    typedef struct packed {
        ps2_state_e  st;
        logic [63:0] sbuf;
        logic [2:0]  cnt;
        logic        emit;
        logic [63:0] word;
        logic        err;
    } step_t;

    function automatic logic is_response(input logic [7:0] b);
        return b inside {RSP_ACK, RSP_BAT_OK, RSP_ECHO, RSP_RESEND,
                         RSP_BAT_ERR, RSP_OVR0, RSP_OVR1};
    endfunction

endpackage

// File: rtl/ps2_timeout_ctr.sv
// Idle-gap counter: cleared on every byte, counts while enabled, and pulses
// expired in the cycle the count reaches TIMEOUT_CYC.
module ps2_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 48000,
    parameter int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt;

    // A byte in the same cycle suppresses the expiry
    assign expired = enable && !clear && (cnt == LAST);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || !enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/ps2_key_encoder.sv
// Groups the raw PS/2 set-2 byte stream into 65-bit ps2_key events
// (toggle bit + zero-filled scan-code sequence).
module ps2_key_encoder
    import ps2_key_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 48000,
    parameter int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic [KEY_W-1:0] ps2_key,
    output logic             key_strobe,
    output logic             err
);

    ps2_state_e  state, state_n;
    logic [63:0] sbuf, sbuf_n;
    logic [2:0]  cnt, cnt_n;
    logic        pend, pend_n;
    logic [63:0] pend_word, pend_word_n;
    logic [KEY_W-1:0] key_n;
    logic        strobe_n, err_n;
    logic        expired;

    logic        emit;
    logic [63:0] emit_word;
    logic [63:0] held, tail;
    logic [7:0]  hold_exp;
    logic        hold_last;
    step_t       nx;

    ps2_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TO_W       (TO_W)
    ) u_timeout (
        .clk_sys(clk_sys),
        .reset  (reset),
        .clear  (byte_valid),
        .enable (state != IDLE),
        .expired(expired)
    );

    function automatic step_t idle_step(input logic [7:0] b);
        step_t s;
        s    = '0;
        s.st = IDLE;
        if (!is_response(b)) begin
            if (b == PFX_E0 || b == BRK_F0) begin
                s.st   = PREFIX;
                s.sbuf = {56'd0, b};
            end else if (b == PFX_E1) begin
                s.st   = PAUSE;
                s.sbuf = {56'd0, b};
                s.cnt  = 3'd1;
            end else begin
                s.emit = 1'b1;
                s.word = {56'd0, b};
            end
        end
        return s;
    endfunction

    function automatic step_t prefix_step(input logic [63:0] pbuf, input logic [7:0] b);
        step_t s;
        s      = '0;
        s.st   = PREFIX;
        s.sbuf = {pbuf[55:0], b};
        if (b == PFX_E0 || b == BRK_F0) begin
            // Only E0 F0 is a legal prefix pair; anything else restarts on b
            if (!(pbuf == 64'(PFX_E0) && b == BRK_F0)) begin
                s     = idle_step(b);
                s.err = 1'b1;
            end
        end else if (pbuf == 64'(PFX_E0) && b == KEY_LSHIFT) begin
            s.st = HOLD_MAKE;
        end else if (pbuf == {48'd0, PFX_E0, BRK_F0} && b == KEY_PRTSC) begin
            s.st = HOLD_BRK;
        end else begin
            s.st   = IDLE;
            s.sbuf = '0;
            s.emit = 1'b1;
            s.word = {pbuf[55:0], b};
        end
        return s;
    endfunction

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sbuf       <= '0;
            cnt        <= '0;
            pend       <= 1'b0;
            pend_word  <= '0;
            ps2_key    <= '0;
            key_strobe <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            sbuf       <= sbuf_n;
            cnt        <= cnt_n;
            pend       <= pend_n;
            pend_word  <= pend_word_n;
            ps2_key    <= key_n;
            key_strobe <= strobe_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        sbuf_n      = sbuf;
        cnt_n       = cnt;
        pend_n      = 1'b0;
        pend_word_n = pend_word;
        err_n       = 1'b0;
        emit        = 1'b0;
        emit_word   = '0;
        nx          = '0;

        // cnt counts tail bytes received while holding; held part sits above them
        case (cnt)
            3'd1:    begin held = sbuf >> 8;  tail = {56'd0, sbuf[7:0]};  end
            3'd2:    begin held = sbuf >> 16; tail = {48'd0, sbuf[15:0]}; end
            default: begin held = sbuf;       tail = '0;                  end
        endcase

        if (state == HOLD_BRK) begin
            hold_exp  = (cnt == 3'd0) ? PFX_E0 : (cnt == 3'd1) ? BRK_F0 : KEY_LSHIFT;
            hold_last = (cnt == 3'd2);
        end else begin
            hold_exp  = (cnt == 3'd0) ? PFX_E0 : KEY_PRTSC;
            hold_last = (cnt == 3'd1);
        end

        if (pend) begin
            emit      = 1'b1;
            emit_word = pend_word;
        end else if (byte_valid) begin
            case (state)
                IDLE, PREFIX: begin
                    nx      = (state == IDLE) ? idle_step(byte_data) : prefix_step(sbuf, byte_data);
                    state_n = nx.st;
                    sbuf_n  = nx.sbuf;
                    cnt_n   = nx.cnt;
                    err_n   = nx.err;
                    emit    = nx.emit;
                    emit_word = nx.word;
                end
                PAUSE: begin
                    if (cnt == 3'd7) begin
                        emit      = 1'b1;
                        emit_word = {sbuf[55:0], byte_data};
                        sbuf_n    = '0;
                        cnt_n     = '0;
                        state_n   = IDLE;
                    end else begin
                        sbuf_n = {sbuf[55:0], byte_data};
                        cnt_n  = cnt + 3'd1;
                    end
                end
                HOLD_MAKE, HOLD_BRK: begin
                    if (byte_data == hold_exp) begin
                        if (hold_last) begin
                            emit      = 1'b1;
                            emit_word = {sbuf[55:0], byte_data};
                            sbuf_n    = '0;
                            cnt_n     = '0;
                            state_n   = IDLE;
                        end else begin
                            sbuf_n = {sbuf[55:0], byte_data};
                            cnt_n  = cnt + 3'd1;
                        end
                    end else begin
                        // Held bytes go out now; the tail restarts as a prefix and any
                        // event it completes with this byte is deferred one cycle
                        emit        = 1'b1;
                        emit_word   = held;
                        nx          = (tail == '0) ? idle_step(byte_data) : prefix_step(tail, byte_data);
                        state_n     = nx.st;
                        sbuf_n      = nx.sbuf;
                        cnt_n       = nx.cnt;
                        err_n       = nx.err;
                        pend_n      = nx.emit;
                        pend_word_n = nx.word;
                    end
                end
                default: begin
                    state_n = IDLE;
                    sbuf_n  = '0;
                    cnt_n   = '0;
                end
            endcase
        end else if (expired) begin
            if (state == HOLD_MAKE || state == HOLD_BRK) begin
                emit      = 1'b1;
                emit_word = held;
            end else begin
                err_n = 1'b1;
            end
            sbuf_n  = '0;
            cnt_n   = '0;
            state_n = IDLE;
        end

        key_n    = emit ? {~ps2_key[KEY_W-1], emit_word} : ps2_key;
        strobe_n = emit;
    end

endmodule
